bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter that produces the two-digit decimal value shown on the FND.
//  Accepts a binary sample via a valid/ready handshake and clamps it to 0..99.
//  Converts it with a shift-add-3 (double-dabble) datapath over 7 clocks.
//  Holds the ones and tens digits stable as registered outputs, wired straight to the FND digit inputs.
// PARAMETERS
//  IN_WIDTH   8   width of iBin; legal range 7..16
//  SATURATE   1   1: iBin>99 clamps to 99 and sets oOvf; 0: iBin>99 converts (iBin mod 100), oOvf still set
// PORTS
//  iCLK      in   1         system clock; single clock domain
//  iRST      in   1         reset, synchronous, active-low
//  iValid    in   1         iBin is valid this cycle
//  iBin      in   IN_WIDTH  unsigned binary sample
//  oReady    out  1         converter idle; sample accepted when iValid&&oReady at rising edge
//  oDone     out  1         one-cycle pulse: oDigit_1/oDigit_2/oOvf just updated
//  oDigit_1  out  4         ones digit (BCD 0..9), to FND iDigit_1
//  oDigit_2  out  4         tens digit (BCD 0..9), to FND iDigit_2
//  oOvf      out  1         last accepted sample exceeded 99
// BEHAVIOUR
//  - Reset (iRST==0 at a rising edge):
//    - oDigit_1=0, oDigit_2=0, oOvf=0, oDone=0, oReady=1.
//    - State=IDLE, shift count=0, scratch cleared.
//    - An in-flight conversion is aborted and no oDone is issued.
//  - States:
//    - IDLE: oReady=1. On iValid, capture and go to SHIFT.
//    - SHIFT: oReady=0. Runs 7 dabble steps, then returns to IDLE.
//  - Accept at edge T:
//    - val = (iBin>99) ? (SATURATE ? 99 : iBin%100) : iBin.
//    - Load val[6:0] into the 7-bit binary shift register, clear the 8-bit BCD scratch, count=0.
//    - Latch ovf_pend = (iBin>99).
//    - The mod-100 path is needed only when SATURATE=0. It is a combinational compare/subtract
//      chain sized for IN_WIDTH, with no extra cycle.
//  - Each SHIFT edge (T+1..T+7):
//    - Each scratch nibble >=5 gets +3 (4-bit add, no carry out).
//    - Then {scratch, bin} shifts left by 1, MSB-first; count++.
//  - Edge T+7 (count reaches 7):
//    - oDigit_2 = scratch[7:4], oDigit_1 = scratch[3:0], oOvf = ovf_pend.
//    - oDone=1 for exactly the following cycle; state=IDLE, so oReady=1 in that same cycle.
//  - Timing:
//    - Latency is 7 clocks from the accept edge to the output update.
//    - Back-to-back accepts are allowed in the oDone cycle, giving a throughput of 1 sample per 8 clocks.
//  - iValid while oReady=0 is ignored: no queue, no error, and the current conversion is unaffected.
//  - Between updates, outputs hold their last value, so the FND never displays a partial result.
//  - Digits are always in 0..9. Values A..F never reach the FND from this block.
// STRUCTURE
//  - Shared package bin2bcd_pkg holds:
//    - state enum {ST_IDLE, ST_SHIFT}
//    - localparams BCD_MAX=99, DABBLE_STEPS=7, ADJ_THRESH=4'd5, ADJ_ADD=4'd3
//  - Sub-module bcd_dabble_step is purely combinational:
//    - inputs: 8-bit scratch and the incoming binary MSB
//    - output: next 8-bit scratch (adjust then shift)
//  - The top level owns the FSM, counter, shift register and output registers.
// TESTING
//  - Reset, then iBin=0 accepted -> after 7 clk: oDone=1 once, oDigit_2=0, oDigit_1=0, oOvf=0.
//  - iBin=42 -> oDigit_2=4, oDigit_1=2. Then iBin=99 -> 9,9, oOvf=0; iBin=7 -> 0,7.
//  - SATURATE=1, iBin=200 -> 9,9, oOvf=1. SATURATE=0, iBin=137 -> 3,7, oOvf=1.
//  - iValid held high continuously with 10,11,12:
//    - accepts occur every 8 clk
//    - oReady low during SHIFT
//    - a value driven mid-conversion is not captured
//  - iRST low at T+3 of a conversion of 55 -> outputs 0, no oDone. A subsequent 55 -> 5,5.
//  - Exhaustive sweep 0..255 (IN_WIDTH=8) against a reference model:
//    - digits match min(v,99) (SATURATE=1)
//    - outputs are stable whenever oDone=0

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
//   state_t       : converter FSM states
//   bcd2_t        : two-digit BCD payload (tens, ones)
//   dabble_adjust : add-3 correction applied to one BCD nibble before a shift
package bin2bcd_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int unsigned BCD_MAX      = 99;
    localparam int unsigned DABBLE_STEPS = 7;
    localparam int unsigned BIN_W        = 7;   // bits needed for 0..99
    localparam int unsigned SCR_W        = 8;   // two BCD nibbles
    localparam int unsigned CNT_W        = 3;   // counts 0..DABBLE_STEPS

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    // Nibbles >= 5 would exceed 9 after doubling; pre-add 3 so the shift carries into the next digit.
    function automatic logic [3:0] dabble_adjust(input logic [3:0] i_nib);
        return (i_nib >= ADJ_THRESH) ? 4'(i_nib + ADJ_ADD) : i_nib;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble step: adjust each BCD nibble, then shift
// the scratch left by one with the next binary bit entering at the LSB.
//   i_scratch   : current 8-bit BCD scratch
//   i_bin_msb   : next binary bit (MSB-first)
//   o_scratch_c : scratch after adjust and shift
module bcd_dabble_step
    import bin2bcd_pkg::*;
(
    input  bcd2_t i_scratch,
    input  logic  i_bin_msb,
    output bcd2_t o_scratch_c
);

    // Adjusted tens MSB falls off the top; the cast keeps the low SCR_W bits.
    assign o_scratch_c = bcd2_t'(SCR_W'({dabble_adjust(i_scratch.tens),
                                         dabble_adjust(i_scratch.ones),
                                         i_bin_msb}));

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter for a two-digit FND display.
// Accepts a sample on iValid&&oReady, clamps (or reduces mod 100) values
// above 99, converts over 7 clocks and holds the digits until the next result.
//   iCLK, iRST         : clock, synchronous active-low reset
//   iValid, iBin       : sample handshake input
//   oReady             : idle, sample accepted at the next rising edge
//   oDone              : one-cycle pulse when digits/oOvf update
//   oDigit_1, oDigit_2 : ones and tens BCD digits
//   oOvf               : last accepted sample exceeded 99
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 8,
    parameter bit          SATURATE = 1'b1
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iValid,
    input  logic [IN_WIDTH-1:0] iBin,
    output logic                oReady,
    output logic                oDone,
    output logic [3:0]          oDigit_1,
    output logic [3:0]          oDigit_2,
    output logic                oOvf
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIN_W-1:0]   r_bin;
    bcd2_t              r_scratch;
    logic               r_ovf_pend;
    logic               r_ready;
    logic               r_done;
    logic [3:0]         r_digit_1;
    logic [3:0]         r_digit_2;
    logic               r_ovf;

    logic               w_over;
    logic [BIN_W-1:0]   w_val;
    bcd2_t              w_next_scratch;

    // Conditional-subtract chain: 100<<k for k from the top down leaves x mod 100.
    function automatic logic [BIN_W-1:0] mod100(input logic [IN_WIDTH-1:0] i_x);
        logic [IN_WIDTH-1:0] rem;
        rem = i_x;
        for (int k = int'(IN_WIDTH) - int'(BIN_W); k >= 0; k--) begin
            if (rem >= (IN_WIDTH'(BCD_MAX + 1) << k)) begin
                rem = rem - (IN_WIDTH'(BCD_MAX + 1) << k);
            end
        end
        return rem[BIN_W-1:0];
    endfunction

    assign w_over = (iBin > IN_WIDTH'(BCD_MAX));

    // Range reduction of the incoming sample to 0..99.
    generate
        if (SATURATE) begin : g_sat
            assign w_val = w_over ? BIN_W'(BCD_MAX) : iBin[BIN_W-1:0];
        end else begin : g_mod
            assign w_val = w_over ? mod100(iBin) : iBin[BIN_W-1:0];
        end
    endgenerate

    bcd_dabble_step u_step (
        .i_scratch   (r_scratch),
        .i_bin_msb   (r_bin[BIN_W-1]),
        .o_scratch_c (w_next_scratch)
    );

    // Converter FSM, shift datapath and output registers.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bin      <= '0;
            r_scratch  <= '0;
            r_ovf_pend <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_digit_1  <= 4'd0;
            r_digit_2  <= 4'd0;
            r_ovf      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (iValid) begin
                        r_bin      <= w_val;
                        r_scratch  <= '0;
                        r_cnt      <= '0;
                        r_ovf_pend <= w_over;
                        r_ready    <= 1'b0;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_scratch <= w_next_scratch;
                    r_bin     <= {r_bin[BIN_W-2:0], 1'b0};
                    r_cnt     <= r_cnt + CNT_W'(1);
                    // Last step: publish the freshly shifted scratch directly.
                    if (r_cnt == CNT_W'(DABBLE_STEPS - 1)) begin
                        r_digit_2 <= w_next_scratch.tens;
                        r_digit_1 <= w_next_scratch.ones;
                        r_ovf     <= r_ovf_pend;
                        r_done    <= 1'b1;
                        r_ready   <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign oReady   = r_ready;
    assign oDone    = r_done;
    assign oDigit_1 = r_digit_1;
    assign oDigit_2 = r_digit_2;
    assign oOvf     = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a saturating 8-bit instance and a mod-100 12-bit
// instance, checked against an arithmetic decimal reference model.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       vs, rs, ds, so;
    logic [7:0] bs;
    logic [3:0] s1, s2;
    logic       vm, rm, dm, mo;
    logic [11:0] bm;
    logic [3:0] m1, m2;

    int n_checks = 0;
    int n_pass   = 0;

    bin2bcd_seq #(.IN_WIDTH(8), .SATURATE(1'b1)) u_sat (
        .iCLK(clk), .iRST(rst_n), .iValid(vs), .iBin(bs),
        .oReady(rs), .oDone(ds), .oDigit_1(s1), .oDigit_2(s2), .oOvf(so)
    );

    bin2bcd_seq #(.IN_WIDTH(12), .SATURATE(1'b0)) u_mod (
        .iCLK(clk), .iRST(rst_n), .iValid(vm), .iBin(bm),
        .oReady(rm), .oDone(dm), .oDigit_1(m1), .oDigit_2(m2), .oOvf(mo)
    );

    // Decimal reference: reduce to 0..99 by the overflow rule, then split digits.
    function automatic logic [8:0] ref_conv(input int v, input bit sat);
        int m;
        bit ovf;
        ovf = (v > 99);
        m   = !ovf ? v : (sat ? 99 : v % 100);
        return {4'(m / 10), 4'(m % 10), ovf};
    endfunction

    // Issues one sample and reports what the DUT did; returns observations only.
    task automatic conv(input bit use_mod, input int v, output bit rdy0, output int lat,
                        output int unstable, output logic [8:0] res,
                        output logic done_after, output logic rdy_after);
        logic [8:0] prev, cur;
        rdy0 = use_mod ? rm : rs;
        prev = use_mod ? {m2, m1, mo} : {s2, s1, so};
        if (use_mod) begin vm = 1'b1; bm = 12'(v); end
        else         begin vs = 1'b1; bs = 8'(v);  end
        @(posedge clk); #1;
        vm = 1'b0; vs = 1'b0;
        lat = -1; unstable = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            cur = use_mod ? {m2, m1, mo} : {s2, s1, so};
            if ((use_mod ? dm : ds) === 1'b1) begin lat = c; break; end
            if (cur !== prev) unstable++;
        end
        res = use_mod ? {m2, m1, mo} : {s2, s1, so};
        @(posedge clk); #1;
        done_after = use_mod ? dm : ds;
        rdy_after  = use_mod ? rm : rs;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({rs, ds, s2, s1, so} !== {1'b1, 1'b0, 8'h00, 1'b0})
            $display("FAIL reset_sat: got %b expected %b", {rs, ds, s2, s1, so}, {1'b1, 1'b0, 8'h00, 1'b0});
        else n_pass++;
        n_checks++;
        if ({rm, dm, m2, m1, mo} !== {1'b1, 1'b0, 8'h00, 1'b0})
            $display("FAIL reset_mod: got %b expected %b", {rm, dm, m2, m1, mo}, {1'b1, 1'b0, 8'h00, 1'b0});
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({rs, ds} !== 2'b10) $display("FAIL idle_after_reset: got %b expected 10", {rs, ds});
        else n_pass++;
    endtask

    task automatic test_directed();
        int  dv[10] = '{0, 42, 99, 7, 200, 137, 99, 100, 4095, 0};
        bit  dm_[10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        bit  rdy0; int lat, unst; logic [8:0] res, exp_r; logic da, ra;
        for (int i = 0; i < 10; i++) begin
            conv(dm_[i], dv[i], rdy0, lat, unst, res, da, ra);
            exp_r = ref_conv(dv[i], !dm_[i]);
            n_checks++;
            if (rdy0 !== 1'b1) $display("FAIL dir_ready v=%0d: got %b expected 1", dv[i], rdy0);
            else n_pass++;
            n_checks++;
            if (lat !== 7) $display("FAIL dir_latency v=%0d: got %0d expected 7", dv[i], lat);
            else n_pass++;
            n_checks++;
            if (res !== exp_r) $display("FAIL dir_result v=%0d mod=%0d: got %h,%h ovf=%b expected %h,%h ovf=%b",
                                        dv[i], dm_[i], res[8:5], res[4:1], res[0], exp_r[8:5], exp_r[4:1], exp_r[0]);
            else n_pass++;
            n_checks++;
            if ({da, ra} !== 2'b01) $display("FAIL dir_single_pulse v=%0d: got done=%b ready=%b expected done=0 ready=1", dv[i], da, ra);
            else n_pass++;
            n_checks++;
            if (unst !== 0) $display("FAIL dir_stable v=%0d: got %0d changes expected 0", dv[i], unst);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int vals[3] = '{10, 11, 12};
        logic exp_h; logic [8:0] exp_r;
        n_checks++;
        if (rs !== 1'b1) $display("FAIL b2b_start_ready: got %b expected 1", rs);
        else n_pass++;
        vs = 1'b1;
        for (int i = 0; i < 24; i++) begin
            // Off-slot values would corrupt the result if sampled mid-conversion.
            bs = (i % 8 == 0) ? 8'(vals[i / 8]) : 8'(60 + i);
            @(posedge clk); #1;
            exp_h = (i % 8 == 7);
            n_checks++;
            if ({rs, ds} !== {exp_h, exp_h})
                $display("FAIL b2b_handshake step=%0d: got ready=%b done=%b expected %b,%b", i, rs, ds, exp_h, exp_h);
            else n_pass++;
            if (exp_h) begin
                exp_r = ref_conv(vals[i / 8], 1'b1);
                n_checks++;
                if ({s2, s1, so} !== exp_r)
                    $display("FAIL b2b_result step=%0d: got %h expected %h", i, {s2, s1, so}, exp_r);
                else n_pass++;
            end
        end
        vs = 1'b0;
    endtask

    task automatic test_reset_abort();
        bit rdy0; int lat, unst, pulses; logic [8:0] res; logic da, ra;
        conv(1'b0, 42, rdy0, lat, unst, res, da, ra);
        n_checks++;
        if (res !== 9'h084) $display("FAIL abort_pre: got %h expected 084", res);
        else n_pass++;
        vs = 1'b1; bs = 8'd55;
        @(posedge clk); #1;
        vs = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if ({rs, ds, s2, s1, so} !== {1'b1, 1'b0, 8'h00, 1'b0})
            $display("FAIL abort_state: got %b expected %b", {rs, ds, s2, s1, so}, {1'b1, 1'b0, 8'h00, 1'b0});
        else n_pass++;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (ds === 1'b1 || {s2, s1} !== 8'h00) pulses++;
        end
        n_checks++;
        if (pulses !== 0) $display("FAIL abort_no_done: got %0d events expected 0", pulses);
        else n_pass++;
        conv(1'b0, 55, rdy0, lat, unst, res, da, ra);
        n_checks++;
        if ({lat, res} !== {32'd7, 9'h0AA}) $display("FAIL abort_recover: got lat=%0d res=%h expected lat=7 res=0aa", lat, res);
        else n_pass++;
    endtask

    task automatic test_sweep();
        bit rdy0; int lat, unst; logic [8:0] res, exp_r; logic da, ra;
        for (int v = 0; v < 256; v++) begin
            conv(1'b0, v, rdy0, lat, unst, res, da, ra);
            exp_r = ref_conv(v, 1'b1);
            n_checks++;
            if (res !== exp_r) $display("FAIL sweep_result v=%0d: got %h expected %h", v, res, exp_r);
            else n_pass++;
            n_checks++;
            if ({lat, unst} !== {32'd7, 32'd0}) $display("FAIL sweep_timing v=%0d: got lat=%0d changes=%0d expected 7,0", v, lat, unst);
            else n_pass++;
        end
    endtask

    task automatic test_random_mod();
        bit rdy0; int v, lat, unst; logic [8:0] res, exp_r; logic da, ra;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            v = int'($urandom_range(0, 4095));
            conv(1'b1, v, rdy0, lat, unst, res, da, ra);
            exp_r = ref_conv(v, 1'b0);
            n_checks++;
            if ({lat, res} !== {32'd7, exp_r})
                $display("FAIL mod_random v=%0d: got lat=%0d res=%h expected lat=7 res=%h", v, lat, res, exp_r);
            else n_pass++;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; vs = 1'b0; bs = '0; vm = 1'b0; bm = '0;
        #1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        test_random_mod();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
